// File: rtl/mst_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mst_rd_arbiter_pkg : shared types and constants for the PLB master read arbiter
// Revision 1.0
// ============================================================================
package mst_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic OWNER_VID      = 1'b0;
    localparam logic OWNER_GEN      = 1'b1;
    localparam int   BYTES_PER_BEAT = 4;

endpackage
`default_nettype wire

// File: rtl/mst_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// mst_rd_arbiter_if : requester handshakes plus PLB master read port signals
// Revision 1.0
// ============================================================================
interface mst_rd_arbiter_if #(
    parameter int DW   = 32,
    parameter int LENW = 12
);
    logic            req0_valid;
    logic [31:0]     req0_addr;
    logic [LENW-1:0] req0_len;
    logic            req0_ack;
    logic            req1_valid;
    logic [31:0]     req1_addr;
    logic [LENW-1:0] req1_len;
    logic            req1_ack;

    logic [DW-1:0]   rd0_data;
    logic            rd0_valid;
    logic [DW-1:0]   rd1_data;
    logic            rd1_valid;
    logic            done0;
    logic            done1;
    logic            err0;
    logic            err1;

    logic            IP2Bus_MstRd_Req;
    logic [31:0]     IP2Bus_Mst_Addr;
    logic [LENW-1:0] IP2Bus_Mst_Length;
    logic            Bus2IP_Mst_CmdAck;
    logic            Bus2IP_Mst_Cmplt;
    logic            Bus2IP_Mst_Error;
    logic [DW-1:0]   Bus2IP_MstRd_d;
    logic            Bus2IP_MstRd_src_rdy_n;
    logic            IP2Bus_MstRd_dst_rdy_n;

    // Arbiter side
    modport master (
        input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
        input  Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
        output req0_ack, req1_ack, rd0_data, rd0_valid, rd1_data, rd1_valid,
        output done0, done1, err0, err1,
        output IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length, IP2Bus_MstRd_dst_rdy_n
    );

    // Requesters and bus side
    modport slave (
        output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
        output Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
        input  req0_ack, req1_ack, rd0_data, rd0_valid, rd1_data, rd1_valid,
        input  done0, done1, err0, err1,
        input  IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length, IP2Bus_MstRd_dst_rdy_n
    );

endinterface
`default_nettype wire

// File: rtl/mst_rd_arbiter.sv
`default_nettype none
// ============================================================================
// mst_rd_arbiter : shares the PLB master read port between video and a general client
// Revision 1.0
// ============================================================================
module mst_rd_arbiter
    import mst_rd_arbiter_pkg::*;
#(
    parameter int DW          = 8 * BYTES_PER_BEAT,
    parameter int LENW        = 12,
    parameter int MAX_VID_RUN = 4
) (
    input  logic             Bus2IP_Clk,
    input  logic             Bus2IP_Resetn,
    mst_rd_arbiter_if.master bus
);

    localparam int         BPB         = DW / 8;
    localparam logic [3:0] VID_RUN_MAX = 4'(MAX_VID_RUN);

    state_e          r_state;
    logic            r_owner;
    logic            r_bad;
    logic            r_mst_req;
    logic [31:0]     r_addr;
    logic [LENW-1:0] r_len;
    logic [3:0]      r_vid_run;
    logic            r_ack0;
    logic            r_ack1;
    logic            r_done0;
    logic            r_done1;
    logic            r_err0;
    logic            r_err1;

    logic            w_pick0;
    logic            w_pick1;
    logic [31:0]     w_sel_addr;
    logic [LENW-1:0] w_sel_len;
    logic            w_grant_ok;
    logic            w_window;
    logic            w_beat0;
    logic            w_beat1;
    logic            w_finish;
    logic            w_fin_err;

    function automatic logic req_ok(input logic [31:0] addr, input logic [LENW-1:0] len);
        return (len != '0) && ((len % LENW'(BPB)) == '0) && ((addr % 32'(BPB)) == '0);
    endfunction

    // Video wins unless the general client has already waited out a full video run
    assign w_pick1    = bus.req1_valid && (!bus.req0_valid || (r_vid_run == VID_RUN_MAX));
    assign w_pick0    = bus.req0_valid && !w_pick1;
    assign w_sel_addr = w_pick1 ? bus.req1_addr : bus.req0_addr;
    assign w_sel_len  = w_pick1 ? bus.req1_len  : bus.req0_len;
    assign w_grant_ok = req_ok(w_sel_addr, w_sel_len);

    // The CmdAck cycle also opens the data window so a beat arriving alongside
    // an immediate Cmplt is still delivered.
    assign w_window = (r_state == ST_XFER) ||
                      ((r_state == ST_CMD) && !r_bad && bus.Bus2IP_Mst_CmdAck);
    assign w_beat0  = w_window && !bus.Bus2IP_MstRd_src_rdy_n && (r_owner == OWNER_VID);
    assign w_beat1  = w_window && !bus.Bus2IP_MstRd_src_rdy_n && (r_owner == OWNER_GEN);

    assign w_finish  = ((r_state == ST_CMD) &&
                        (r_bad || (bus.Bus2IP_Mst_CmdAck && bus.Bus2IP_Mst_Cmplt))) ||
                       ((r_state == ST_XFER) && bus.Bus2IP_Mst_Cmplt);
    assign w_fin_err = r_bad || bus.Bus2IP_Mst_Error;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWNER_VID;
            r_bad     <= 1'b0;
            r_mst_req <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_vid_run <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pick0 || w_pick1) begin
                        r_owner   <= w_pick1 ? OWNER_GEN : OWNER_VID;
                        r_addr    <= w_sel_addr;
                        r_len     <= w_sel_len;
                        r_bad     <= !w_grant_ok;
                        r_mst_req <= w_grant_ok;
                        r_ack0    <= w_pick0;
                        r_ack1    <= w_pick1;
                        r_state   <= ST_CMD;
                        if (w_pick1 || !bus.req1_valid) begin
                            r_vid_run <= '0;
                        end else if (r_vid_run != VID_RUN_MAX) begin
                            r_vid_run <= r_vid_run + 4'd1;
                        end
                    end
                end
                ST_CMD: begin
                    if (bus.Bus2IP_Mst_CmdAck) begin
                        r_mst_req <= 1'b0;
                    end
                    if (w_finish) begin
                        r_state <= ST_DONE;
                    end else if (bus.Bus2IP_Mst_CmdAck) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_finish) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bad   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_finish) begin
                r_done0 <= (r_owner == OWNER_VID);
                r_done1 <= (r_owner == OWNER_GEN);
                r_err0  <= (r_owner == OWNER_VID) && w_fin_err;
                r_err1  <= (r_owner == OWNER_GEN) && w_fin_err;
            end
        end
    end

    assign bus.req0_ack               = r_ack0;
    assign bus.req1_ack               = r_ack1;
    assign bus.rd0_valid              = w_beat0;
    assign bus.rd1_valid              = w_beat1;
    assign bus.rd0_data               = w_beat0 ? bus.Bus2IP_MstRd_d : '0;
    assign bus.rd1_data               = w_beat1 ? bus.Bus2IP_MstRd_d : '0;
    assign bus.done0                  = r_done0;
    assign bus.done1                  = r_done1;
    assign bus.err0                   = r_err0;
    assign bus.err1                   = r_err1;
    assign bus.IP2Bus_MstRd_Req       = r_mst_req;
    assign bus.IP2Bus_Mst_Addr        = r_addr;
    assign bus.IP2Bus_Mst_Length      = r_len;
    assign bus.IP2Bus_MstRd_dst_rdy_n = !w_window;

endmodule
`default_nettype wire

// File: tb/tb_mst_rd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mst_rd_arbiter : scoreboard bench with a PLB read responder model
// Revision 1.0
// ============================================================================
module tb_mst_rd_arbiter;
    import mst_rd_arbiter_pkg::*;

    localparam int DW          = 32;
    localparam int LENW        = 12;
    localparam int MAX_VID_RUN = 4;

    typedef struct packed { logic owner; logic [31:0] data; } beat_t;
    typedef struct packed { logic [31:0] addr; logic [LENW-1:0] len; } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mst_rd_arbiter_if #(.DW(DW), .LENW(LENW)) bus ();

    mst_rd_arbiter #(.DW(DW), .LENW(LENW), .MAX_VID_RUN(MAX_VID_RUN)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Resetn(rst_n),
        .bus          (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    beat_t      beat_q[$];
    logic [1:0] done_q[$];
    logic       grant_q[$];
    cmd_t       cmd_q[$];

    int beats0 = 0, beats1 = 0, dones = 0, acks = 0, cmds = 0;
    int stray_req = 0, stray_done = 0;
    bit same_cycle = 0, err_mode = 0, err_glitch = 0, abort_mode = 0, abort_req = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input int i);
        return (a + 32'(i * 4)) ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic owner_of(input logic [31:0] a);
        return (a[31:28] == 4'h2);
    endfunction

    // Output monitor: pops the scoreboard on every beat, ack and done
    beat_t      m_beat;
    logic [1:0] m_done;
    logic       m_grant;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd0_valid || bus.rd1_valid) begin
                check("rd_onehot", 64'(bus.rd0_valid) + 64'(bus.rd1_valid), 64'd1);
                if (bus.rd0_valid) beats0++; else beats1++;
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 64'(beat_q.size()), 64'd1);
                end else begin
                    m_beat = beat_q.pop_front();
                    check("beat_owner", 64'(bus.rd1_valid), 64'(m_beat.owner));
                    check("beat_data", 64'(bus.rd1_valid ? bus.rd1_data : bus.rd0_data), 64'(m_beat.data));
                end
            end
            if (bus.req0_ack || bus.req1_ack) begin
                check("ack_onehot", 64'(bus.req0_ack) + 64'(bus.req1_ack), 64'd1);
                acks++;
                if (grant_q.size() == 0) begin
                    check("ack_unexpected", 64'(grant_q.size()), 64'd1);
                end else begin
                    m_grant = grant_q.pop_front();
                    check("grant_owner", 64'(bus.req1_ack), 64'(m_grant));
                end
            end
            if (bus.done0 || bus.done1) begin
                check("done_onehot", 64'(bus.done0) + 64'(bus.done1), 64'd1);
                dones++;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'(done_q.size()), 64'd1);
                end else begin
                    m_done = done_q.pop_front();
                    check("done_owner", 64'(bus.done1), 64'(m_done[1]));
                    check("done_err", 64'(bus.done1 ? bus.err1 : bus.err0), 64'(m_done[0]));
                end
            end
            if (bus.err0 || bus.err1)
                check("err_with_done", 64'({bus.err0 & ~bus.done0, bus.err1 & ~bus.done1}), 64'd0);
        end
    end

    // PLB read responder
    task automatic serve();
        logic [31:0] a;
        int          n;
        cmd_t        e;
        a = bus.IP2Bus_Mst_Addr;
        n = int'(bus.IP2Bus_Mst_Length) / 4;
        cmds++;
        if (cmd_q.size() == 0) begin
            check("cmd_unexpected", 64'(cmd_q.size()), 64'd1);
        end else begin
            e = cmd_q.pop_front();
            check("cmd_addr", 64'(a), 64'(e.addr));
            check("cmd_len", 64'(bus.IP2Bus_Mst_Length), 64'(e.len));
        end
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        if (same_cycle) begin
            bus.Bus2IP_Mst_Cmplt       = 1'b1;
            bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
            bus.Bus2IP_MstRd_d         = pat(a, 0);
            beat_q.push_back({owner_of(a), pat(a, 0)});
            done_q.push_back({owner_of(a), 1'b0});
            @(posedge clk); #1;
            bus.Bus2IP_Mst_CmdAck      = 1'b0;
            bus.Bus2IP_Mst_Cmplt       = 1'b0;
            bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
            return;
        end
        @(posedge clk); #1;
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
            bus.Bus2IP_MstRd_d         = pat(a, i);
            if (abort_mode && i == 10) begin
                abort_req = 1'b1;
                @(posedge clk); #1;
                bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
                abort_req = 1'b0;
                return;
            end
            bus.Bus2IP_Mst_Error = err_glitch && (i == 0);
            beat_q.push_back({owner_of(a), pat(a, i)});
            @(posedge clk); #1;
            bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
            bus.Bus2IP_Mst_Error       = 1'b0;
        end
        bus.Bus2IP_Mst_Cmplt = 1'b1;
        bus.Bus2IP_Mst_Error = err_mode;
        done_q.push_back({owner_of(a), err_mode});
        @(posedge clk); #1;
        bus.Bus2IP_Mst_Cmplt = 1'b0;
        bus.Bus2IP_Mst_Error = 1'b0;
    endtask

    initial begin
        bus.Bus2IP_Mst_CmdAck      = 1'b0;
        bus.Bus2IP_Mst_Cmplt       = 1'b0;
        bus.Bus2IP_Mst_Error       = 1'b0;
        bus.Bus2IP_MstRd_d         = '0;
        bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) continue;
            if (stray_done != stray_req) begin
                bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
                bus.Bus2IP_MstRd_d         = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
                stray_done++;
            end
            if (rst_n && bus.IP2Bus_MstRd_Req) serve();
        end
    end

    task automatic wait_dones(input int target, input int budget);
        int c = 0;
        while (dones < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_timeout", 64'(dones >= target), 64'd1);
    endtask

    task automatic wait_acks(input int target, input int budget);
        int c = 0;
        while (acks < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("ack_timeout", 64'(acks >= target), 64'd1);
    endtask

    // One request from one requester; addr/len are scrambled after ack
    task automatic issue(input bit who, input logic [31:0] a, input logic [LENW-1:0] len, input bit bad);
        int a0 = acks;
        int d0 = dones;
        grant_q.push_back(who);
        if (bad) done_q.push_back({who, 1'b1});
        else     cmd_q.push_back({a, len});
        @(posedge clk); #1;
        if (!who) begin
            bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_len = len;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_len = len;
        end
        wait_acks(a0 + 1, 50);
        bus.req0_valid = 1'b0; bus.req0_addr = 32'hFFFF_FFF0; bus.req0_len = 12'hFF0;
        bus.req1_valid = 1'b0; bus.req1_addr = 32'hFFFF_FFF0; bus.req1_len = 12'hFF0;
        wait_dones(d0 + 1, 3000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulses"}, 64'({bus.req0_ack, bus.req1_ack, bus.rd0_valid, bus.rd1_valid,
                                      bus.done0, bus.done1, bus.err0, bus.err1}), 64'd0);
        check({tag, "_req"}, 64'(bus.IP2Bus_MstRd_Req), 64'd0);
        check({tag, "_dst_rdy_n"}, 64'(bus.IP2Bus_MstRd_dst_rdy_n), 64'd1);
        check({tag, "_addr_len"}, 64'({bus.IP2Bus_Mst_Addr, bus.IP2Bus_Mst_Length}), 64'd0);
    endtask

    initial begin
        int c0, b0, b1, d0, a0, cnt;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_len = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: video only, 64 beats, a stray beat beforehand must be ignored
        stray_req++;
        repeat (4) @(posedge clk);
        c0 = cmds; b0 = beats0; b1 = beats1; d0 = dones;
        issue(1'b0, 32'h1000_0000, 12'd256, 1'b0);
        check("t1_cmds", 64'(cmds - c0), 64'd1);
        check("t1_beats0", 64'(beats0 - b0), 64'd64);
        check("t1_beats1", 64'(beats1 - b1), 64'd0);
        check("t1_dones", 64'(dones - d0), 64'd1);

        // 2: both held, fairness pattern 0,0,0,0,1 repeated
        a0 = acks; d0 = dones;
        for (int i = 0; i < 10; i++) begin
            grant_q.push_back(i % 5 == 4);
            if (i % 5 == 4) cmd_q.push_back({32'h2000_0000, 12'd16});
            else            cmd_q.push_back({32'h1000_4000, 12'd16});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h1000_4000; bus.req0_len = 12'd16;
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h2000_0000; bus.req1_len = 12'd16;
        wait_acks(a0 + 10, 2000);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_dones(d0 + 10, 500);

        // 3: error on general burst, then a clean video burst with an Error glitch mid-beat
        err_mode = 1'b1;
        issue(1'b1, 32'h2000_1000, 12'd32, 1'b0);
        err_mode   = 1'b0;
        err_glitch = 1'b1;
        issue(1'b0, 32'h1000_8000, 12'd32, 1'b0);
        err_glitch = 1'b0;

        // 4: invalid requests never reach the bus
        c0 = cmds;
        issue(1'b0, 32'h1000_0000, 12'd0, 1'b1);
        issue(1'b1, 32'h2000_0002, 12'd16, 1'b1);
        issue(1'b0, 32'h1000_0000, 12'd6, 1'b1);
        check("t4_no_cmd", 64'(cmds - c0), 64'd0);

        // 5: CmdAck and Cmplt together with the single beat
        same_cycle = 1'b1;
        b0 = beats0; d0 = dones;
        issue(1'b0, 32'h1000_C000, 12'd4, 1'b0);
        same_cycle = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_beats0", 64'(beats0 - b0), 64'd1);
        check("t5_done_once", 64'(dones - d0), 64'd1);

        // 6: reset during beat 10, then clean service
        abort_mode = 1'b1;
        b0 = beats0; a0 = acks;
        grant_q.push_back(1'b0);
        cmd_q.push_back({32'h1000_0000, 12'd256});
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h1000_0000; bus.req0_len = 12'd256;
        wait_acks(a0 + 1, 50);
        bus.req0_valid = 1'b0;
        cnt = 0;
        while (!abort_req && cnt < 2000) begin
            @(posedge clk); #2;
            cnt++;
        end
        check("t6_abort_seen", 64'(abort_req), 64'd1);
        rst_n = 1'b0;
        abort_mode = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        check("t6_beats_before", 64'(beats0 - b0), 64'd10);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        b0 = beats0;
        issue(1'b0, 32'h1000_2000, 12'd64, 1'b0);
        check("t6_beats_after", 64'(beats0 - b0), 64'd16);

        repeat (5) @(negedge clk);
        check("queues_empty", 64'(beat_q.size() + done_q.size() + grant_q.size() + cmd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
